// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared constants, divisor word type and helpers for clk_en_gen
package clk_en_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int DEFAULT_DIV = 2;

    typedef logic [CNT_W_DEF-1:0] div_word_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/clk_en_ch.sv
// clk_en_ch: one divider channel producing a tick enable and a square wave
module clk_en_ch
    import clk_en_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV0  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             sq,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend_div;
    logic             wrap;

    assign wrap = cnt == div - CNT_W'(1);

    // Count, realign on sync, and swap in a pending divisor only when the period restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div      <= CNT_W'(DIV0);
            pend_div <= '0;
            pend     <= 1'b0;
            tick     <= 1'b0;
            sq       <= 1'b0;
        end else begin
            if (sync) begin
                cnt  <= '0;
                sq   <= 1'b0;
                tick <= 1'b0;
                if (pend) div <= pend_div;
            end else if (!en) begin
                tick <= 1'b0;
                if (pend) begin
                    div <= pend_div;
                    cnt <= '0;
                end
            end else if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
                sq   <= ~sq;
                if (pend) div <= pend_div;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
            pend <= load ? 1'b1 : (sync || !en || wrap) ? 1'b0 : pend;
            if (load) pend_div <= load_div;
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel runtime-programmable clock-enable generator
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = clk_en_pkg::DEFAULT_DIV,
    parameter int CH_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] pend
);

    logic wr_ok;

    // Channel index is widened by one bit so NUM_CH=16 still compares correctly.
    assign wr_ok = cfg_div != '0 && {1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH);

    // Flag writes that carry a zero divisor or address a missing channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err <= 1'b0;
        else cfg_err <= cfg_we && !wr_ok;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_en_ch #(
            .CNT_W (CNT_W),
            .DIV0  (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[g]),
            .sync     (sync),
            .load     (cfg_we && wr_ok && cfg_ch == CH_W'(g)),
            .load_div (cfg_div),
            .tick     (tick[g]),
            .sq       (sq[g]),
            .pend     (pend[g])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: scoreboard bench comparing clk_en_gen against a countdown model
module tb_clk_en_gen;
    import clk_en_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = CNT_W_DEF;
    localparam int CH_W   = 4;
    localparam int DDIV   = 2;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b1;
    logic [NUM_CH-1:0] en      = '0;
    logic              sync    = 1'b0;
    logic              cfg_we  = 1'b0;
    logic [CH_W-1:0]   cfg_ch  = '0;
    div_word_t         cfg_div = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] pend;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] sq;
        logic [NUM_CH-1:0] pend;
        logic              err;
    } exp_t;

    exp_t q[$];

    // Model state: cycles remaining until the next tick, rather than an up-counter.
    int m_div[NUM_CH];
    int m_pdiv[NUM_CH];
    int m_rem[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_sq[NUM_CH];
    bit m_tick[NUM_CH];

    always #5 clk = ~clk;

    clk_en_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DDIV),
        .CH_W        (CH_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_err (cfg_err),
        .tick    (tick),
        .sq      (sq),
        .pend    (pend)
    );

    task automatic chk(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]  = DDIV;
            m_pdiv[i] = 0;
            m_rem[i]  = DDIV;
            m_pend[i] = 0;
            m_sq[i]   = 0;
            m_tick[i] = 0;
        end
    endfunction

    function automatic void apply_pending(input int i);
        if (m_pend[i]) begin
            m_div[i]  = m_pdiv[i];
            m_pend[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        exp_t x;
        int ch  = int'(cfg_ch);
        int dv  = int'(cfg_div);
        bit err = cfg_we && (dv == 0 || ch >= NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync) begin
                apply_pending(i);
                m_rem[i]  = m_div[i];
                m_sq[i]   = 0;
                m_tick[i] = 0;
            end else if (!en[i]) begin
                m_tick[i] = 0;
                if (m_pend[i]) begin
                    apply_pending(i);
                    m_rem[i] = m_div[i];
                end
            end else begin
                m_rem[i]--;
                m_tick[i] = m_rem[i] == 0;
                if (m_tick[i]) begin
                    m_sq[i] = !m_sq[i];
                    apply_pending(i);
                    m_rem[i] = m_div[i];
                end
            end
            if (cfg_we && !err && ch == i) begin
                m_pdiv[i] = dv;
                m_pend[i] = 1;
            end
            x.tick[i] = m_tick[i];
            x.sq[i]   = m_sq[i];
            x.pend[i] = m_pend[i];
        end
        x.err = err;
        q.push_back(x);
    endfunction

    task automatic step(input logic [NUM_CH-1:0] e, input logic s, input logic w, input int ch, input int dv);
        en      = e;
        sync    = s;
        cfg_we  = w;
        cfg_ch  = CH_W'(ch);
        cfg_div = CNT_W'(dv);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step('1, 1'b0, 1'b0, 0, 1);
    endtask

    task automatic do_reset(input bit mid);
        cfg_we = 1'b0;
        sync   = 1'b0;
        if (mid) begin
            @(posedge clk);
            #2;
        end
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("rst_tick", tick, '0);
        chk("rst_sq", sq, '0);
        chk("rst_pend", pend, '0);
        chk("rst_err", NUM_CH'(cfg_err), '0);
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hold_tick", tick, '0);
            chk("rst_hold_sq", sq, '0);
            chk("rst_hold_pend", pend, '0);
        end
        en    = '1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: one expectation per clock edge, checked on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("tick", tick, e.tick);
            chk("sq", sq, e.sq);
            chk("pend", pend, e.pend);
            chk("cfg_err", NUM_CH'(cfg_err), NUM_CH'(e.err));
        end
    end

    initial begin
        #1;
        do_reset(0);
        run(12);

        // ch1 to div 5, then retarget to 3 mid-period
        step('1, 1'b0, 1'b1, 1, 5);
        run(12);
        for (int k = 0; k < 10 && m_rem[1] != 3; k++) step('1, 1'b0, 1'b0, 0, 1);
        step('1, 1'b0, 1'b1, 1, 3);
        run(20);

        // write landing exactly in the wrap cycle of ch1
        for (int k = 0; k < 10 && m_rem[1] != 1; k++) step('1, 1'b0, 1'b0, 0, 1);
        step('1, 1'b0, 1'b1, 1, 4);
        run(15);

        // rejected writes, then a last-write-wins pair
        step('1, 1'b0, 1'b1, 1, 0);
        step('1, 1'b0, 1'b1, 7, 3);
        run(10);
        step('1, 1'b0, 1'b1, 0, 7);
        step('1, 1'b0, 1'b1, 0, 2);
        run(10);

        // enable gating on ch2 at div 4, dropped when cnt reaches 2
        step('1, 1'b0, 1'b1, 2, 4);
        run(10);
        for (int k = 0; k < 10 && m_rem[2] != 2; k++) step('1, 1'b0, 1'b0, 0, 1);
        for (int k = 0; k < 10; k++) step(4'b1011, 1'b0, 1'b0, 0, 1);
        run(8);
        step(4'b1011, 1'b0, 1'b1, 2, 6);
        step(4'b1011, 1'b0, 1'b0, 0, 1);
        run(10);

        // divisors 3/5/7/9 then global sync with a pending write
        for (int i = 0; i < NUM_CH; i++) step('1, 1'b0, 1'b1, i, 3 + 2 * i);
        run(20);
        step('1, 1'b0, 1'b1, 0, 6);
        step('1, 1'b1, 1'b0, 0, 1);
        run(12);
        step(4'b0101, 1'b1, 1'b1, 3, 4);
        run(12);

        // asynchronous reset while ch1 holds a pending divisor
        for (int k = 0; k < 20 && m_rem[1] < 3; k++) step('1, 1'b0, 1'b0, 0, 1);
        step('1, 1'b0, 1'b1, 1, 7);
        do_reset(1);
        run(10);

        // randomized traffic, divisors kept small so wraps are frequent
        for (int k = 0; k < 400; k++) begin
            logic [NUM_CH-1:0] e;
            e = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '1;
            step(e, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 9)));
        end
        run(4);

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
